// File: rtl/cache_miss_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_ctrl_if
//  Description : Cache-bank and memory-bus signal bundle for cache_miss_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_miss_ctrl_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_NUM   = 4
);
    // Cache bank side
    logic                           miss_cache;
    logic [ADDR_WIDTH-1:0]          addr_cache;
    logic                           set_cache;
    logic                           need_wb;
    logic [ADDR_WIDTH-1:0]          addr_wb;
    logic [BANK_NUM*DATA_WIDTH-1:0] data_wb;
    logic                           busy_wb;
    logic                           busy_rd;
    logic [ADDR_WIDTH-1:0]          addr_rd;
    logic [2*DATA_WIDTH-1:0]        data_rd;
    logic                           wen_rd;
    logic                           set_rd;
    logic                           finish_rd;
    // Memory side
    logic                           mem_req_valid;
    logic                           mem_req_ready;
    logic                           mem_req_wen;
    logic [ADDR_WIDTH-1:0]          mem_req_addr;
    logic [2*DATA_WIDTH-1:0]        mem_req_wdata;
    logic                           mem_resp_valid;
    logic [2*DATA_WIDTH-1:0]        mem_resp_data;

    // The miss controller is the master of both the refill port and the memory bus.
    modport master (
        input  miss_cache, addr_cache, set_cache, need_wb, addr_wb, data_wb,
        output busy_wb, busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        output miss_cache, addr_cache, set_cache, need_wb, addr_wb, data_wb,
        input  busy_wb, busy_rd, addr_rd, data_rd, wen_rd, set_rd, finish_rd,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_miss_ctrl
//  Description : Cache miss handler: optional dirty-line write-back, then a
//                line read whose beats are streamed back into the cache bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_miss_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BANK_NUM   = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cache_miss_ctrl_if.master  bus
);
    localparam int BEATS      = BANK_NUM / 2;
    localparam int BEAT_W     = 2 * DATA_WIDTH;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] BEAT_STRIDE = ADDR_WIDTH'(BEAT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB      = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_DATA = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t                         state_q,   state_d;
    logic [CNT_W-1:0]               beat_q,    beat_d;
    logic [ADDR_WIDTH-1:0]          rd_base_q, rd_base_d;
    logic [ADDR_WIDTH-1:0]          wb_base_q, wb_base_d;
    logic                           way_q,     way_d;
    logic [BEATS-1:0][BEAT_W-1:0]   wb_line_q, wb_line_d;
    logic                           wen_rd_q,  wen_rd_d;
    logic [ADDR_WIDTH-1:0]          addr_rd_q, addr_rd_d;
    logic [BEAT_W-1:0]              data_rd_q, data_rd_d;
    logic                           set_rd_q,  set_rd_d;

    logic                           w_req_valid;
    logic                           w_req_wen;
    logic [ADDR_WIDTH-1:0]          w_req_addr;
    logic [BEAT_W-1:0]              w_req_wdata;
    logic [ADDR_WIDTH-1:0]          w_beat_offset;

    assign w_beat_offset = ADDR_WIDTH'(beat_q) * BEAT_STRIDE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            beat_q    <= '0;
            rd_base_q <= '0;
            wb_base_q <= '0;
            way_q     <= 1'b0;
            wb_line_q <= '0;
            wen_rd_q  <= 1'b0;
            addr_rd_q <= '0;
            data_rd_q <= '0;
            set_rd_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rd_base_q <= rd_base_d;
            wb_base_q <= wb_base_d;
            way_q     <= way_d;
            wb_line_q <= wb_line_d;
            wen_rd_q  <= wen_rd_d;
            addr_rd_q <= addr_rd_d;
            data_rd_q <= data_rd_d;
            set_rd_q  <= set_rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        rd_base_d   = rd_base_q;
        wb_base_d   = wb_base_q;
        way_d       = way_q;
        wb_line_d   = wb_line_q;
        wen_rd_d    = 1'b0;
        addr_rd_d   = addr_rd_q;
        data_rd_d   = data_rd_q;
        set_rd_d    = set_rd_q;
        w_req_valid = 1'b0;
        w_req_wen   = 1'b0;
        w_req_addr  = '0;
        w_req_wdata = '0;

        unique case (state_q)
            S_IDLE: begin
                // The bank invalidates the victim on this edge, so the whole line is snapshotted now.
                if (bus.miss_cache) begin
                    rd_base_d = bus.addr_cache;
                    way_d     = bus.set_cache;
                    beat_d    = '0;
                    if (bus.need_wb) begin
                        wb_base_d = bus.addr_wb;
                        wb_line_d = bus.data_wb;
                        state_d   = S_WB;
                    end else begin
                        state_d   = S_RD_REQ;
                    end
                end
            end
            S_WB: begin
                w_req_valid = 1'b1;
                w_req_wen   = 1'b1;
                w_req_addr  = wb_base_q + w_beat_offset;
                w_req_wdata = wb_line_q[beat_q];
                if (bus.mem_req_ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = S_RD_REQ;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                    end
                end
            end
            S_RD_REQ: begin
                w_req_valid = 1'b1;
                w_req_addr  = rd_base_q;
                if (bus.mem_req_ready) begin
                    beat_d  = '0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (bus.mem_resp_valid) begin
                    wen_rd_d  = 1'b1;
                    addr_rd_d = rd_base_q + w_beat_offset;
                    data_rd_d = bus.mem_resp_data;
                    set_rd_d  = way_q;
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_FINISH;
                    end else begin
                        beat_d  = beat_q + CNT_W'(1);
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, not only after the edge.
    assign bus.busy_wb       = !rst && (state_q == S_WB);
    assign bus.busy_rd       = !rst && ((state_q == S_RD_REQ) || (state_q == S_RD_DATA) ||
                                        (state_q == S_FINISH));
    assign bus.finish_rd     = !rst && (state_q == S_FINISH);
    assign bus.wen_rd        = !rst && wen_rd_q;
    assign bus.addr_rd       = rst ? '0 : addr_rd_q;
    assign bus.data_rd       = rst ? '0 : data_rd_q;
    assign bus.set_rd        = !rst && set_rd_q;
    assign bus.mem_req_valid = !rst && w_req_valid;
    assign bus.mem_req_wen   = !rst && w_req_wen;
    assign bus.mem_req_addr  = rst ? '0 : w_req_addr;
    assign bus.mem_req_wdata = rst ? '0 : w_req_wdata;

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_miss_ctrl
//  Description : Randomized and directed bench for cache_miss_ctrl with a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_miss_ctrl;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int BN    = 4;
    localparam int BEATS = BN / 2;
    localparam int BW2   = 2 * DW;
    localparam int BB    = BW2 / 8;

    typedef struct {
        logic          wen;
        logic [AW-1:0] addr;
        logic [BW2-1:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_miss_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) bus ();

    cache_miss_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding memory requests plus refill progress.
    req_t           rq[$];
    logic           m_busy   = 1'b0;
    logic           m_finish = 1'b0;
    logic           m_pend   = 1'b0;
    logic [AW-1:0]  m_paddr  = '0;
    logic [BW2-1:0] m_pdata  = '0;
    logic           m_pset   = 1'b0;
    logic [AW-1:0]  m_base   = '0;
    logic           m_way    = 1'b0;
    int             m_k      = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW2-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        return a & ~AW'(BN * DW / 8 - 1);
    endfunction

    always @(negedge clk) begin : compare
        req_t           hd;
        logic           ev, ebw, ebr, np, ns;
        logic [AW-1:0]  na;
        logic [BW2-1:0] nd;
        if (rst) begin
            chk("rst busy_wb", bus.busy_wb, 0);
            chk("rst busy_rd", bus.busy_rd, 0);
            chk("rst finish_rd", bus.finish_rd, 0);
            chk("rst wen_rd", bus.wen_rd, 0);
            chk("rst set_rd", bus.set_rd, 0);
            chk("rst addr_rd", bus.addr_rd, 0);
            chk("rst data_rd", bus.data_rd, 0);
            chk("rst mem_req_valid", bus.mem_req_valid, 0);
            chk("rst mem_req_wen", bus.mem_req_wen, 0);
            chk("rst mem_req_addr", bus.mem_req_addr, 0);
            chk("rst mem_req_wdata", bus.mem_req_wdata, 0);
            rq.delete();
            m_busy = 0; m_finish = 0; m_pend = 0; m_k = 0;
        end else begin
            ev = m_busy && (rq.size() > 0);
            if (ev) hd = rq[0];
            else    hd = '{wen: 1'b0, addr: '0, data: '0};
            ebw = ev && hd.wen;
            ebr = m_busy && !ebw;
            chk("mem_req_valid", bus.mem_req_valid, ev);
            chk("busy_wb", bus.busy_wb, ebw);
            chk("busy_rd", bus.busy_rd, ebr);
            chk("finish_rd", bus.finish_rd, m_finish);
            chk("wen_rd", bus.wen_rd, m_pend);
            if (ev) begin
                chk("mem_req_wen", bus.mem_req_wen, hd.wen);
                chk("mem_req_addr", bus.mem_req_addr, hd.addr);
                if (hd.wen) chk("mem_req_wdata", bus.mem_req_wdata, hd.data);
            end
            if (m_pend) begin
                chk("addr_rd", bus.addr_rd, m_paddr);
                chk("data_rd", bus.data_rd, m_pdata);
                chk("set_rd", bus.set_rd, m_pset);
            end
            np = 1'b0; na = m_paddr; nd = m_pdata; ns = m_pset;
            if (m_finish) begin
                m_finish = 0;
                m_busy   = 0;
            end else if (!m_busy) begin
                if (bus.miss_cache) begin
                    if (bus.need_wb)
                        for (int b = 0; b < BEATS; b++)
                            rq.push_back('{wen: 1'b1, addr: bus.addr_wb + AW'(b * BB),
                                           data: bus.data_wb[b*BW2 +: BW2]});
                    rq.push_back('{wen: 1'b0, addr: bus.addr_cache, data: '0});
                    m_base = bus.addr_cache;
                    m_way  = bus.set_cache;
                    m_k    = 0;
                    m_busy = 1;
                end
            end else if (rq.size() > 0) begin
                if (bus.mem_req_ready) void'(rq.pop_front());
            end else if (bus.mem_resp_valid) begin
                np = 1'b1;
                na = m_base + AW'(m_k * BB);
                nd = bus.mem_resp_data;
                ns = m_way;
                if (m_k == BEATS - 1) m_finish = 1;
                else                  m_k++;
            end
            m_pend = np; m_paddr = na; m_pdata = nd; m_pset = ns;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.miss_cache     = 0;
        bus.addr_cache     = '0;
        bus.set_cache      = 0;
        bus.need_wb        = 0;
        bus.addr_wb        = '0;
        bus.data_wb        = '0;
        bus.mem_req_ready  = 0;
        bus.mem_resp_valid = 0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic start_miss(input logic [AW-1:0] a, input logic s, input logic wb,
                              input logic [AW-1:0] awb, input logic [BN*DW-1:0] dwb);
        bus.miss_cache = 1; bus.addr_cache = a; bus.set_cache = s;
        bus.need_wb = wb; bus.addr_wb = awb; bus.data_wb = dwb;
        tick();
        bus.miss_cache = 0;
    endtask

    task automatic run_refill(input int max);
        int n = 0;
        bus.mem_req_ready = 1;
        while ((bus.busy_rd || bus.busy_wb) && n < max) begin
            bus.mem_resp_valid = 1'($urandom_range(0, 1));
            bus.mem_resp_data  = rnd_beat();
            tick();
            n++;
        end
        bus.mem_resp_valid = 0;
        checks++;
        if (n >= max) begin
            errors++;
            $display("FAIL refill_timeout: still busy after %0d cycles, required idle", n);
        end
    endtask

    localparam logic [DW-1:0]  W0 = 64'h0000_0000_0000_00A0;
    localparam logic [DW-1:0]  W1 = 64'h1111_1111_1111_11A1;
    localparam logic [DW-1:0]  W2 = 64'h2222_2222_2222_22A2;
    localparam logic [DW-1:0]  W3 = 64'h3333_3333_3333_33A3;
    localparam logic [BW2-1:0] BA = 128'hAAAA_0000_AAAA_0001_AAAA_0002_AAAA_0003;
    localparam logic [BW2-1:0] BBD = 128'hBBBB_0000_BBBB_0001_BBBB_0002_BBBB_0003;

    initial begin
        logic [AW-1:0]  wb_addr_lit [2];
        logic [BW2-1:0] wb_data_lit [2];
        int             ready_mode;
        wb_addr_lit[0] = 64'h2000;            wb_addr_lit[1] = 64'h2010;
        wb_data_lit[0] = {W1, W0};            wb_data_lit[1] = {W3, W2};

        idle_inputs();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        @(negedge clk);
        chk("post-reset busy_rd", bus.busy_rd, 0);
        chk("post-reset mem_req_valid", bus.mem_req_valid, 0);
        chk("post-reset addr_rd", bus.addr_rd, 0);

        // Spurious response beats while idle.
        bus.mem_resp_valid = 1; bus.mem_resp_data = BA;
        repeat (3) tick();
        bus.mem_resp_valid = 0;

        // Clean miss with literal expectations.
        start_miss(64'h1000, 1'b1, 1'b0, '0, '0);
        bus.mem_req_ready = 1;
        @(negedge clk);
        chk("clean req valid", bus.mem_req_valid, 1);
        chk("clean req addr", bus.mem_req_addr, 64'h1000);
        chk("clean req wen", bus.mem_req_wen, 0);
        tick();
        bus.mem_req_ready = 0; bus.mem_resp_valid = 1; bus.mem_resp_data = BA;
        tick();
        bus.mem_resp_data = BBD;
        @(negedge clk);
        chk("clean beat0 wen", bus.wen_rd, 1);
        chk("clean beat0 addr", bus.addr_rd, 64'h1000);
        chk("clean beat0 data", bus.data_rd, BA);
        chk("clean beat0 finish", bus.finish_rd, 0);
        tick();
        bus.mem_resp_valid = 0;
        @(negedge clk);
        chk("clean beat1 wen", bus.wen_rd, 1);
        chk("clean beat1 addr", bus.addr_rd, 64'h1010);
        chk("clean beat1 data", bus.data_rd, BBD);
        chk("clean finish", bus.finish_rd, 1);
        chk("clean set_rd", bus.set_rd, 1);
        tick();
        @(negedge clk);
        chk("clean done busy_rd", bus.busy_rd, 0);
        chk("clean done wen_rd", bus.wen_rd, 0);

        // Dirty miss under backpressure, with spurious miss/resp during WB.
        tick();
        bus.mem_req_ready = 0;
        start_miss(64'h3000, 1'b0, 1'b1, 64'h2000, {W3, W2, W1, W0});
        bus.miss_cache = 1; bus.addr_cache = 64'h4000; bus.need_wb = 0;
        bus.mem_resp_valid = 1; bus.mem_resp_data = BA;
        for (int b = 0; b < BEATS; b++) begin
            for (int r = 0; r < 4; r++) begin
                bus.mem_req_ready = (r == 3);
                @(negedge clk);
                chk("wb req addr", bus.mem_req_addr, wb_addr_lit[b]);
                chk("wb req wdata", bus.mem_req_wdata, wb_data_lit[b]);
                chk("wb busy_wb", bus.busy_wb, 1);
                chk("wb no wen_rd", bus.wen_rd, 0);
                tick();
            end
        end
        bus.miss_cache = 0; bus.mem_resp_valid = 0; bus.mem_req_ready = 1;
        @(negedge clk);
        chk("dirty read addr", bus.mem_req_addr, 64'h3000);
        chk("dirty read wen", bus.mem_req_wen, 0);
        chk("dirty busy_wb low", bus.busy_wb, 0);
        tick();
        run_refill(200);

        // Reset in the middle of a write-back.
        tick();
        bus.mem_req_ready = 0;
        start_miss(64'h6000, 1'b1, 1'b1, 64'h7000, {rnd_beat(), rnd_beat()});
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst-wb busy_wb", bus.busy_wb, 0);
        chk("rst-wb mem_req_valid", bus.mem_req_valid, 0);
        chk("rst-wb mem_req_addr", bus.mem_req_addr, 0);

        // Reset in the middle of a refill.
        tick();
        bus.mem_req_ready = 1;
        start_miss(64'h5000, 1'b1, 1'b0, '0, '0);
        tick();
        bus.mem_resp_valid = 1; bus.mem_resp_data = BA;
        tick();
        bus.mem_resp_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("rst-rd busy_rd", bus.busy_rd, 0);
        chk("rst-rd wen_rd", bus.wen_rd, 0);
        chk("rst-rd data_rd", bus.data_rd, 0);
        chk("rst-rd set_rd", bus.set_rd, 0);
        tick();
        start_miss(64'h8000, 1'b0, 1'b0, '0, '0);
        run_refill(200);

        // Randomized traffic, checked cycle by cycle against the model.
        ready_mode = 0;
        for (int c = 0; c < 6000; c++) begin
            if (c % 1500 == 0) ready_mode = c / 1500;
            rst                = ($urandom_range(0, 399) == 0);
            bus.miss_cache     = ($urandom_range(0, 3) == 0);
            bus.addr_cache     = rnd_addr();
            bus.set_cache      = 1'($urandom);
            bus.need_wb        = 1'($urandom);
            bus.addr_wb        = rnd_addr();
            bus.data_wb        = {rnd_beat(), rnd_beat()};
            case (ready_mode)
                0:       bus.mem_req_ready = 1'($urandom);
                1:       bus.mem_req_ready = 1;
                2:       bus.mem_req_ready = ($urandom_range(0, 4) == 0);
                default: bus.mem_req_ready = ($urandom_range(0, 3) != 0);
            endcase
            bus.mem_resp_valid = ($urandom_range(0, 2) != 0);
            bus.mem_resp_data  = rnd_beat();
            tick();
        end
        rst = 0;
        idle_inputs();
        bus.mem_req_ready = 1;
        run_refill(200);
        repeat (3) tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
